multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 55 +++++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// Inputs to the controller: opcode (latched inst[6:0]), zero (ALU flag),
// mem_ready (unified memory completes this cycle).
// Outputs from the controller: memory strobes (mem_req, mem_we, iord),
// datapath strobes (ir_we, pc_we, pc_src, alusrc, memtoreg, regwrite, aluop),
// status (state, trap) and, with MCTRL_PERF_EN, cycle_cnt/instret_cnt.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned CNT_W = 32;

    logic [OP_W-1:0]  opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             alusrc;
    logic             memtoreg;
    logic             regwrite;
    logic [1:0]       aluop;
    logic [2:0]       state;
    logic             trap;
`ifdef MCTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alusrc, memtoreg, regwrite, aluop, state, trap,
               cycle_cnt, instret_cnt
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alusrc, memtoreg, regwrite, aluop, state, trap,
               cycle_cnt, instret_cnt
    );
`else
    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alusrc, memtoreg, regwrite, aluop, state, trap
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alusrc, memtoreg, regwrite, aluop, state, trap
    );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller (R-type, addi, lw, sw, beq).
// Ports: clk (rising edge), rst (async, active-low), ctrl (multicycle_ctrl_if.master).
// Strobes are decoded from the current state in the same cycle so that the
// FETCH/MEM handshakes can react to mem_ready without an extra cycle; all of
// them are forced low while rst is low.
// Optional feature: define MCTRL_PERF_EN to add cycle_cnt / instret_cnt.
module multicycle_ctrl (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   ctrl
);
    localparam int unsigned OP_W  = 7;
    localparam int unsigned CNT_W = 32;

    localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ADDI = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_RSV5   = 3'd5,
        S_RSV6   = 3'd6,
        S_TRAP   = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] opcode_q, opcode_d;

    logic       mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c, pc_src_c;
    logic       alusrc_c, memtoreg_c, regwrite_c, trap_c;
    logic [1:0] aluop_c;
    logic       legal_c;

    // Opcode legality check on the value being latched in DECODE
    always_comb begin
        unique case (ctrl.opcode)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: legal_c = 1'b1;
            default:                             legal_c = 1'b0;
        endcase
    end

    // State and latched-opcode registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        iord_c     = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_src_c   = 1'b0;
        alusrc_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        aluop_c    = 2'd0;
        trap_c     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (ctrl.mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opcode_d = ctrl.opcode;
                state_d  = legal_c ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                unique case (opcode_q)
                    OP_R: begin
                        aluop_c = 2'd2;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alusrc_c = 1'b1;
                        state_d  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alusrc_c = 1'b1;
                        state_d  = S_MEM;
                    end
                    OP_BEQ: begin
                        aluop_c  = 2'd1;
                        pc_we_c  = ctrl.zero;
                        pc_src_c = ctrl.zero;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                // Write strobe only in the completing cycle: one pulse per sw
                mem_we_c  = (opcode_q == OP_SW) && ctrl.mem_ready;
                if (ctrl.mem_ready) begin
                    state_d = (opcode_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                regwrite_c = 1'b1;
                memtoreg_c = (opcode_q == OP_LW);
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap_c = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // Reset overrides every strobe asynchronously
    assign ctrl.mem_req  = rst & mem_req_c;
    assign ctrl.mem_we   = rst & mem_we_c;
    assign ctrl.iord     = rst & iord_c;
    assign ctrl.ir_we    = rst & ir_we_c;
    assign ctrl.pc_we    = rst & pc_we_c;
    assign ctrl.pc_src   = rst & pc_src_c;
    assign ctrl.alusrc   = rst & alusrc_c;
    assign ctrl.memtoreg = rst & memtoreg_c;
    assign ctrl.regwrite = rst & regwrite_c;
    assign ctrl.aluop    = rst ? aluop_c : 2'd0;
    assign ctrl.trap     = rst & trap_c;
    assign ctrl.state    = state_q;

`ifdef MCTRL_PERF_EN
    logic             retire_c;
    logic [CNT_W-1:0] cycle_q, instret_q;

    // Final cycle of each instruction
    assign retire_c = (state_q == S_WB)
                    || (state_q == S_MEM  && ctrl.mem_ready && opcode_q == OP_SW)
                    || (state_q == S_EXEC && opcode_q == OP_BEQ);

    // Performance counters, wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
            if (retire_c)          instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign ctrl.cycle_cnt   = cycle_q;
    assign ctrl.instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected strobe vectors are
// queued as each instruction is issued and popped/compared every cycle.
module tb_multicycle_ctrl;
    logic clk;
    logic rst;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'h7F;

    typedef struct {
        logic [6:0]  opc;
        logic        zr;
        logic        rdy;
        logic [14:0] v;
        string       tag;
    } step_t;

    step_t       q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_cyc = 0;
    int          n_ret = 0;
    logic [14:0] obs_v;

    // {state, trap, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alusrc, memtoreg, regwrite, aluop}
    assign obs_v = {bus.state, bus.trap, bus.mem_req, bus.mem_we, bus.iord, bus.ir_we,
                    bus.pc_we, bus.pc_src, bus.alusrc, bus.memtoreg, bus.regwrite, bus.aluop};

    function automatic logic [14:0] mkv(input logic [2:0] st, input logic tr, input logic mrq,
                                        input logic mwe, input logic io, input logic irw,
                                        input logic pcw, input logic pcs, input logic asrc,
                                        input logic m2r, input logic rw, input logic [1:0] aop);
        return {st, tr, mrq, mwe, io, irw, pcw, pcs, asrc, m2r, rw, aop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [6:0] opc, input logic zr,
                        input logic rdy, input logic [14:0] v);
        step_t s;
        s.opc = opc; s.zr = zr; s.rdy = rdy; s.v = v; s.tag = tag;
        q.push_back(s);
    endtask

    // Expected per-cycle behaviour of one instruction; opcode input is scrambled
    // after DECODE so only the latched copy can steer the later states.
    task automatic issue(input string name, input logic [6:0] opc, input logic zr,
                         input int fw, input int mw);
        logic legal, is_lw, is_sw;
        legal = (opc == OP_R) || (opc == OP_ADDI) || (opc == OP_LW) ||
                (opc == OP_SW) || (opc == OP_BEQ);
        is_lw = (opc == OP_LW);
        is_sw = (opc == OP_SW);
        for (int i = 0; i < fw; i++)
            push({name, "_fwait"}, opc, zr, 1'b0, mkv(3'd0,0,1,0,0,0,0,0,0,0,0,2'd0));
        push({name, "_fetch"}, opc, zr, 1'b1, mkv(3'd0,0,1,0,0,1,1,0,0,0,0,2'd0));
        push({name, "_decode"}, opc, zr, 1'b1, mkv(3'd1,0,0,0,0,0,0,0,0,0,0,2'd0));
        if (!legal) return;
        n_ret++;
        if (opc == OP_R)
            push({name, "_exec"}, OP_BAD, zr, 1'b1, mkv(3'd2,0,0,0,0,0,0,0,0,0,0,2'd2));
        else if (opc == OP_BEQ)
            push({name, "_exec"}, OP_BAD, zr, 1'b1, mkv(3'd2,0,0,0,0,0,zr,zr,0,0,0,2'd1));
        else
            push({name, "_exec"}, OP_BAD, zr, 1'b1, mkv(3'd2,0,0,0,0,0,0,0,1,0,0,2'd0));
        if (is_lw || is_sw) begin
            for (int i = 0; i < mw; i++)
                push({name, "_mwait"}, OP_BAD, zr, 1'b0, mkv(3'd3,0,1,0,1,0,0,0,0,0,0,2'd0));
            push({name, "_mem"}, OP_BAD, zr, 1'b1, mkv(3'd3,0,1,is_sw,1,0,0,0,0,0,0,2'd0));
        end
        if (!is_sw && opc != OP_BEQ)
            push({name, "_wb"}, OP_BAD, zr, 1'b1, mkv(3'd4,0,0,0,0,0,0,0,0,is_lw,1,2'd0));
    endtask

    // Drain the scoreboard one clock per entry (entered and left at posedge+1)
    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.opcode    = s.opc;
            bus.zero      = s.zr;
            bus.mem_ready = s.rdy;
            @(negedge clk);
            chk(s.tag, 32'(obs_v), 32'(s.v));
            if (s.v[14:12] != 3'd7) n_cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 32'(obs_v), 32'd0);
`ifdef MCTRL_PERF_EN
        chk({tag, "_cycle"}, bus.cycle_cnt, 32'd0);
        chk({tag, "_instret"}, bus.instret_cnt, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b0;
        bus.opcode = 7'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset("reset_hold");
        rst = 1'b1;

        issue("addi", 7'(32'h00500113), 1'b0, 0, 0);
        run_q();
        issue("lw", 7'(32'h0000a003), 1'b0, 0, 2);
        run_q();
        issue("beq_taken", OP_BEQ, 1'b1, 0, 0);
        run_q();
        issue("beq_not", OP_BEQ, 1'b0, 0, 0);
        run_q();
        issue("rtype", OP_R, 1'b0, 0, 0);
        run_q();
        issue("sw", OP_SW, 1'b0, 1, 1);
        run_q();
`ifdef MCTRL_PERF_EN
        chk("perf_cycle", bus.cycle_cnt, 32'(n_cyc));
        chk("perf_instret", bus.instret_cnt, 32'(n_ret));
`endif

        // Illegal opcode: trap holds with mem_ready ignored
        issue("illegal", OP_BAD, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++)
            push("trap_hold", OP_BAD, 1'b1, 1'b1, mkv(3'd7,1,0,0,0,0,0,0,0,0,0,2'd0));
        run_q();
        rst = 1'b0;
        #1;
        chk_reset("trap_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        issue("addi2", OP_ADDI, 1'b0, 0, 0);
        run_q();

        // Reset during the completing sw MEM cycle
        issue("sw_abort", OP_SW, 1'b0, 0, 0);
        void'(q.pop_back());
        run_q();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("sw_abort_mem", 32'(obs_v), 32'(mkv(3'd3,0,1,1,1,0,0,0,0,0,0,2'd0)));
        #1;
        rst = 1'b0;
        #1;
        chk("sw_abort_async", 32'(bus.mem_we), 32'd0);
        @(posedge clk); #1;
        chk_reset("sw_abort_hold");
        rst = 1'b1;
        push("post_reset_fetch", OP_ADDI, 1'b0, 1'b0, mkv(3'd0,0,1,0,0,0,0,0,0,0,0,2'd0));
        run_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
